// File: rtl/mul_column_seq_yjy.sv
//==============================================================================
// Module   : mul_column_seq_yjy
// Brief    : Sequential column-wise multiplier. Latches two LANES-byte operands
//            and streams the 2*LANES-byte product one byte per cycle, LSB
//            first, over a valid/ready interface with backpressure.
//            Optional product register enabled by `MULCOL_PROD_REG_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mul_column_seq_yjy #(
    parameter  int LANES = 4,
    localparam int NCOL  = 2 * LANES,
    localparam int COLW  = (NCOL > 1) ? $clog2(NCOL) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [8*LANES-1:0]   i_a,
    input  logic [8*LANES-1:0]   i_b,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [7:0]           o_data,
    output logic [COLW-1:0]      o_col,
    output logic                 o_last
`ifdef MULCOL_PROD_REG_EN
    ,
    output logic [16*LANES-1:0]  o_prod,
    output logic [0:0]           o_prod_valid
`endif
);

    // Column sum width: N products of 16 bits plus a carry never exceed this.
    localparam int            CW   = 17 + $clog2(LANES);
    localparam logic [COLW-1:0] LAST = COLW'(NCOL - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [8*LANES-1:0]    a_q, a_d;
    logic [8*LANES-1:0]    b_q, b_d;
    logic [COLW-1:0]       k_q, k_d;
    logic [CW-9:0]         carry_q, carry_d;
    logic [CW-1:0]         col_sum;
    logic [15:0]           pp;

    // Column k sum: carry-in plus every byte product a_i*b_j with i+j == k.
    always_comb begin
        col_sum = {8'b0, carry_q};
        pp      = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int j = 0; j < LANES; j++) begin
                if (i + j == int'(k_q)) begin
                    pp      = {8'b0, a_q[8*i +: 8]} * {8'b0, b_q[8*j +: 8]};
                    col_sum = col_sum + CW'(pp);
                end
            end
        end
    end

    // Next-state and output decode; outputs forced to zero while idle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        carry_d = carry_q;
        i_ready = (state_q == ST_IDLE);
        o_valid = (state_q == ST_RUN);
        o_data  = '0;
        o_col   = '0;
        o_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    k_d     = '0;
                    carry_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_data = col_sum[7:0];
                o_col  = k_q;
                o_last = (k_q == LAST);
                if (o_ready) begin
                    carry_d = col_sum[CW-1:8];
                    if (k_q == LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand, column and carry registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            carry_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            carry_q <= carry_d;
        end
    end

`ifdef MULCOL_PROD_REG_EN
    logic [16*LANES-1:0] prod_q, prod_d;
    logic [0:0]          prod_valid_q, prod_valid_d;

    // Product capture: cleared on accept, byte k written on each byte handshake.
    always_comb begin
        prod_d       = prod_q;
        prod_valid_d = 1'b0;
        if (state_q == ST_IDLE && i_valid) begin
            prod_d = '0;
        end else if (state_q == ST_RUN && o_ready) begin
            prod_d[int'(k_q)*8 +: 8] = col_sum[7:0];
            prod_valid_d             = (k_q == LAST);
        end
    end

    // Product register; the valid flag is a one-cycle pulse after the last byte.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prod_q       <= '0;
            prod_valid_q <= '0;
        end else begin
            prod_q       <= prod_d;
            prod_valid_q <= prod_valid_d;
        end
    end

    assign o_prod       = prod_q;
    assign o_prod_valid = prod_valid_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mul_column_seq_yjy.sv
//==============================================================================
// Module   : tb_mul_column_seq_yjy
// Brief    : Scoreboard bench for mul_column_seq_yjy (LANES=4 and LANES=1).
//            Expected bytes come from a full-width integer product.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mul_column_seq_yjy;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // LANES=4 instance signals
    logic        iv0 = 1'b0, ir0, ov0, ol0;
    logic        or0 = 1'b1;
    logic [31:0] a0 = '0, b0 = '0;
    logic [7:0]  od0;
    logic [2:0]  oc0;
    // LANES=1 instance signals
    logic        iv1 = 1'b0, ir1, ov1, ol1;
    logic        or1 = 1'b1;
    logic [7:0]  a1 = '0, b1 = '0;
    logic [7:0]  od1;
    logic [0:0]  oc1;
`ifdef MULCOL_PROD_REG_EN
    logic [63:0] prod0;
    logic [0:0]  pv0;
    logic [15:0] prod1;
    logic [0:0]  pv1;
`endif

    mul_column_seq_yjy #(.LANES(4)) u_dut0 (
        .clk(clk), .rstn(rstn), .i_valid(iv0), .i_ready(ir0), .i_a(a0), .i_b(b0),
        .o_valid(ov0), .o_ready(or0), .o_data(od0), .o_col(oc0), .o_last(ol0)
`ifdef MULCOL_PROD_REG_EN
        , .o_prod(prod0), .o_prod_valid(pv0)
`endif
    );

    mul_column_seq_yjy #(.LANES(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .i_valid(iv1), .i_ready(ir1), .i_a(a1), .i_b(b1),
        .o_valid(ov1), .o_ready(or1), .o_data(od1), .o_col(oc1), .o_last(ol1)
`ifdef MULCOL_PROD_REG_EN
        , .o_prod(prod1), .o_prod_valid(pv1)
`endif
    );

    typedef struct {
        logic [7:0]  d;
        int          col;
        logic        last;
        logic [63:0] prod;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   ready_mode = 1;   // 0 random, 1 always, 2 pattern 1,0,0
    int   pat = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Consumer backpressure for the LANES=4 instance.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       or0 = 1'($urandom_range(0, 1));
            2:       or0 = (pat % 3 == 0);
            default: or0 = 1'b1;
        endcase
        pat = pat + 1;
    end

    // Monitor / scoreboard for LANES=4.
    logic        hold0 = 1'b0;
    logic [11:0] held0;
    logic        pend0 = 1'b0;
    logic [63:0] pexp0 = '0;
    always @(negedge clk) begin
        exp_t e;
        logic pv_exp;
        if (rstn) begin
            pv_exp = pend0;
            pend0  = 1'b0;
`ifdef MULCOL_PROD_REG_EN
            chk("prod_valid0", 64'(pv0), 64'(pv_exp));
            if (pv_exp) chk("prod0", prod0, pexp0);
`endif
            chk("irdy0", 64'(ir0), 64'(!ov0));
            if (!ov0) begin
                chk("idle_zero0", {52'b0, od0, oc0, ol0}, 64'd0);
                hold0 = 1'b0;
            end else begin
                if (hold0) chk("hold0", {52'b0, od0, oc0, ol0}, {52'b0, held0});
                if (or0) begin
                    hold0 = 1'b0;
                    if (q0.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected0: got byte %0h col %0d expected none", od0, oc0);
                    end else begin
                        e = q0.pop_front();
                        chk("data0", 64'(od0), 64'(e.d));
                        chk("col0",  64'(oc0), 64'(e.col));
                        chk("last0", 64'(ol0), 64'(e.last));
                        if (e.last) begin
                            pend0 = 1'b1;
                            pexp0 = e.prod;
                        end
                    end
                end else begin
                    hold0 = 1'b1;
                    held0 = {od0, oc0, ol0};
                end
            end
        end
    end

    // Monitor / scoreboard for LANES=1 (consumer always ready).
    always @(negedge clk) begin
        exp_t e;
        if (rstn) begin
            chk("irdy1", 64'(ir1), 64'(!ov1));
            if (!ov1) begin
                chk("idle_zero1", {54'b0, od1, oc1, ol1}, 64'd0);
            end else if (q1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected1: got byte %0h col %0d expected none", od1, oc1);
            end else begin
                e = q1.pop_front();
                chk("data1", 64'(od1), 64'(e.d));
                chk("col1",  64'(oc1), 64'(e.col));
                chk("last1", 64'(ol1), 64'(e.last));
            end
        end
    end

    task automatic send0(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        exp_t e;
        int n;
        p = {32'b0, a} * {32'b0, b};
        @(negedge clk);
        iv0 = 1'b1; a0 = a; b0 = b;
        n = 0;
        while (!ir0 && n < 200) begin @(negedge clk); n++; end
        if (!ir0) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout0: got i_ready 0 expected 1");
        end
        for (int k = 0; k < 8; k++) begin
            e.d = p[8*k +: 8]; e.col = k; e.last = (k == 7); e.prod = p;
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0; a0 = $urandom; b0 = $urandom;
        @(negedge clk);
        chk("latency_valid0", 64'(ov0), 64'd1);
        chk("latency_col0",   64'(oc0), 64'd0);
    endtask

    task automatic drain0();
        int n = 0;
        while ((q0.size() != 0 || ov0) && n < 500) begin @(negedge clk); n++; end
        if (q0.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain0: got %0d bytes pending expected 0", q0.size());
            q0.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] p1;
        int prev, n;
        // Reset values.
        #12;
        chk("rst_irdy0", 64'(ir0), 64'd1);
        chk("rst_out0",  {52'b0, ov0, od0, oc0}, 64'd0);
        chk("rst_last0", 64'(ol0), 64'd0);
        chk("rst_irdy1", 64'(ir1), 64'd1);
        chk("rst_out1",  {54'b0, ov1, od1, oc1}, 64'd0);
`ifdef MULCOL_PROD_REG_EN
        chk("rst_prod0", prod0, 64'd0);
        chk("rst_pv0",   64'(pv0), 64'd0);
`endif
        @(negedge clk); #1 rstn = 1'b1;

        // Directed products.
        ready_mode = 1;
        send0(32'h0000_0003, 32'h0000_0005);
        drain0();
        send0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain0();
        pat = 1; ready_mode = 2;
        send0(32'h0000_0100, 32'h0000_0100);
        drain0();
        ready_mode = 1;
        send0(32'h1234_5678, 32'h0000_0010);
        drain0();

        // Reset in the middle of a product.
        send0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n = 0;
        while (!(ov0 && oc0 == 3'd3) && n < 50) begin @(negedge clk); n++; end
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid0", 64'(ov0), 64'd0);
        chk("midrst_irdy0",  64'(ir0), 64'd1);
        chk("midrst_data0",  {52'b0, od0, oc0, ol0}, 64'd0);
        q0.delete(); hold0 = 1'b0; pend0 = 1'b0;
        @(negedge clk); #1 rstn = 1'b1;
        send0(32'h0000_0001, 32'h0000_0002);
        drain0();

        // Randomised products with random backpressure.
        ready_mode = 0;
        for (int t = 0; t < 40; t++) begin
            case (t % 10)
                0:       send0(32'h0, $urandom);
                1:       send0($urandom, 32'hFFFF_FFFF);
                default: send0($urandom, $urandom);
            endcase
        end
        drain0();
        ready_mode = 1;

        // LANES=1: i_valid held high, accept every third cycle.
        @(negedge clk);
        iv1 = 1'b1; a1 = 8'hFF; b1 = 8'hFF;
        prev = 0;
        for (int t = 0; t < 10; t++) begin
            n = 0;
            while (!ir1 && n < 20) begin @(negedge clk); n++; end
            if (!ir1) begin
                n_cmp++; n_bad++;
                $display("FAIL accept_timeout1: got i_ready 0 expected 1");
            end
            if (t > 0) chk("gap1", 64'(cyc - prev), 64'd3);
            prev = cyc;
            p1 = {8'b0, a1} * {8'b0, b1};
            e.d = p1[7:0];  e.col = 0; e.last = 1'b0; e.prod = 64'(p1); q1.push_back(e);
            e.d = p1[15:8]; e.col = 1; e.last = 1'b1; q1.push_back(e);
            @(posedge clk);
            #1;
            a1 = 8'($urandom); b1 = 8'($urandom);
        end
        iv1 = 1'b0;
        n = 0;
        while (q1.size() != 0 && n < 20) begin @(negedge clk); n++; end
        chk("drain1", 64'(q1.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
